// File: rtl/adc_scan_if.sv
// Purpose: bundles the sequencer's ADC-receiver, analog-mux, FIFO and power-controller signals.
// Latency: none, wiring only.
// Backpressure: fifo_full from the FIFO side; the ADC side has no backpressure (one-cycle strobes).
//
// Ports (master = sequencer side):
//   in  sample_data, sample_valid, fifo_full
//   out adc_request, mux_addr, bank_en, ch_addr, fifo_data, fifo_wr,
//       power, power_valid, scan_done, overflow_cnt, timeout_flag
interface adc_scan_if #(
    parameter int ADDR_W = 5,
    parameter int MUX_W  = 3,
    parameter int DATA_W = 12
);
    localparam int BANK_N = 1 << (ADDR_W - MUX_W);

    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              fifo_full;

    logic              adc_request;
    logic [MUX_W-1:0]  mux_addr;
    logic [BANK_N-1:0] bank_en;
    logic [ADDR_W-1:0] ch_addr;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_wr;
    logic [DATA_W-1:0] power;
    logic              power_valid;
    logic              scan_done;
    logic [7:0]        overflow_cnt;
    logic              timeout_flag;

    modport master (
        input  sample_data, sample_valid, fifo_full,
        output adc_request, mux_addr, bank_en, ch_addr, fifo_data, fifo_wr,
               power, power_valid, scan_done, overflow_cnt, timeout_flag
    );

    modport slave (
        output sample_data, sample_valid, fifo_full,
        input  adc_request, mux_addr, bank_en, ch_addr, fifo_data, fifo_wr,
               power, power_valid, scan_done, overflow_cnt, timeout_flag
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Purpose: scans analog channels (mux address + bank enable), requests ADC conversions, routes samples to FIFO or power averager.
// Latency: request SETTLE_CYCLES after address change; FIFO write / power update 1 cycle after sample_valid; next channel 2 cycles after it.
// Backpressure: fifo_full drops the sample (counted in overflow_cnt); the scan never stalls.
//
// Ports: clk (80 MHz domain), reset (synchronous, active-low), bus (adc_scan_if.master):
//   sample_data/sample_valid from the SPI ADC receiver, fifo_full from the analog FIFO;
//   adc_request, mux_addr, bank_en, ch_addr to the front end; fifo_data/fifo_wr to the FIFO;
//   power/power_valid to the power controller; scan_done, overflow_cnt, timeout_flag status.
module adc_scan_sequencer #(
    parameter int CH_NUM          = 32,
    parameter int ADDR_W          = 5,
    parameter int MUX_W           = 3,
    parameter int DATA_W          = 12,
    parameter int INVERT          = 1,
    parameter int IGNORED_CHANNEL = 1,
    parameter int POWER_CHANNEL   = 0,
    parameter int AVG_LOG2        = 2,
    parameter int SETTLE_CYCLES   = 8,
    parameter int TIMEOUT         = 255
) (
    input  logic       clk,
    input  logic       reset,
    adc_scan_if.master bus
);

    localparam int BANK_N  = 1 << (ADDR_W - MUX_W);
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES - 1 : TIMEOUT - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int AVG_N   = 1 << AVG_LOG2;
    localparam int NCNT_W  = AVG_LOG2 + 1;

    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_STORE   = 2'd3;

    logic [1:0]        state;
    // Shared down-counter: settling delay in SETTLE, sample timeout in WAIT.
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ch_addr_q;
    logic [BANK_N-1:0] bank_en_q;
    logic              adc_request_q;
    logic [DATA_W-1:0] fifo_data_q;
    logic              fifo_wr_q;
    logic [DATA_W-1:0] power_q;
    logic              power_valid_q;
    logic              scan_done_q;
    logic [7:0]        overflow_cnt_q;
    logic              timeout_flag_q;
    logic [ACC_W-1:0]  acc_q;
    logic [NCNT_W-1:0] acc_n_q;

    logic              sample_take;
    logic              timeout_hit;
    logic              wait_exit;
    logic [DATA_W-1:0] stored_val;
    logic              is_power;
    logic              is_ignored;
    logic [ACC_W-1:0]  acc_sum;
    logic              acc_last;
    logic              ch_wrap;
    logic [ADDR_W-1:0] next_ch;

    // A sample arriving on the expiry cycle takes priority over the timeout.
    assign sample_take = (state == ST_WAIT) && bus.sample_valid;
    assign timeout_hit = (state == ST_WAIT) && !bus.sample_valid && (cnt == '0);
    assign wait_exit   = sample_take || timeout_hit;

    // The all-ones error marker is never inverted so it stays recognisable downstream.
    assign stored_val  = timeout_hit     ? {DATA_W{1'b1}} :
                         (INVERT != 0)   ? ~bus.sample_data : bus.sample_data;

    assign is_power    = (ch_addr_q == ADDR_W'(POWER_CHANNEL));
    assign is_ignored  = (ch_addr_q == ADDR_W'(IGNORED_CHANNEL));
    assign acc_sum     = acc_q + ACC_W'(stored_val);
    assign acc_last    = (acc_n_q == NCNT_W'(AVG_N - 1));
    assign ch_wrap     = (ch_addr_q == ADDR_W'(CH_NUM - 1));
    assign next_ch     = ch_wrap ? '0 : ch_addr_q + ADDR_W'(1);

    // Store-stage actions are taken on the edge leaving WAIT so that the
    // registered strobes appear in the STORE cycle; STORE itself only steps
    // the channel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_SETTLE;
            cnt            <= CNT_W'(SETTLE_CYCLES - 1);
            ch_addr_q      <= '0;
            bank_en_q      <= BANK_N'(1);
            adc_request_q  <= 1'b0;
            fifo_data_q    <= '0;
            fifo_wr_q      <= 1'b0;
            power_q        <= '0;
            power_valid_q  <= 1'b0;
            scan_done_q    <= 1'b0;
            overflow_cnt_q <= '0;
            timeout_flag_q <= 1'b0;
            acc_q          <= '0;
            acc_n_q        <= '0;
        end else begin
            adc_request_q <= 1'b0;
            fifo_wr_q     <= 1'b0;
            power_valid_q <= 1'b0;
            scan_done_q   <= 1'b0;

            case (state)
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state         <= ST_REQUEST;
                        adc_request_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_REQUEST: begin
                    cnt   <= CNT_W'(TIMEOUT - 1);
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_exit) begin
                        state <= ST_STORE;
                        if (timeout_hit) begin
                            timeout_flag_q <= 1'b1;
                        end
                        if (is_power) begin
                            // Error markers would bias the average; skip them.
                            if (!timeout_hit) begin
                                if (acc_last) begin
                                    power_q       <= acc_sum[ACC_W-1:AVG_LOG2];
                                    power_valid_q <= 1'b1;
                                    acc_q         <= '0;
                                    acc_n_q       <= '0;
                                end else begin
                                    acc_q   <= acc_sum;
                                    acc_n_q <= acc_n_q + NCNT_W'(1);
                                end
                            end
                        end else if (!is_ignored) begin
                            if (!bus.fifo_full) begin
                                fifo_wr_q   <= 1'b1;
                                fifo_data_q <= stored_val;
                            end else if (overflow_cnt_q != 8'hFF) begin
                                overflow_cnt_q <= overflow_cnt_q + 8'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_STORE: begin
                    ch_addr_q   <= next_ch;
                    bank_en_q   <= BANK_N'(1) << (next_ch >> MUX_W);
                    scan_done_q <= ch_wrap;
                    cnt         <= CNT_W'(SETTLE_CYCLES - 1);
                    state       <= ST_SETTLE;
                end

                default: begin
                    state <= ST_SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                end
            endcase
        end
    end

    assign bus.adc_request  = adc_request_q;
    assign bus.mux_addr     = ch_addr_q[MUX_W-1:0];
    assign bus.bank_en      = bank_en_q;
    assign bus.ch_addr      = ch_addr_q;
    assign bus.fifo_data    = fifo_data_q;
    assign bus.fifo_wr      = fifo_wr_q;
    assign bus.power        = power_q;
    assign bus.power_valid  = power_valid_q;
    assign bus.scan_done    = scan_done_q;
    assign bus.overflow_cnt = overflow_cnt_q;
    assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Purpose: randomized bench for adc_scan_sequencer against a transaction-level reference model.
// Latency: checks request timing, store-cycle strobes and channel advance per transaction.
// Backpressure: drives fifo_full per transaction and tracks expected drops.
module tb_adc_scan_sequencer;

    localparam int CH_NUM          = 4;
    localparam int ADDR_W          = 5;
    localparam int MUX_W           = 3;
    localparam int DATA_W          = 12;
    localparam int INVERT          = 1;
    localparam int IGNORED_CHANNEL = 1;
    localparam int POWER_CHANNEL   = 0;
    localparam int AVG_LOG2        = 2;
    localparam int SETTLE_CYCLES   = 8;
    localparam int TIMEOUT         = 255;
    localparam int FULL_SCALE      = (1 << DATA_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adc_scan_if #(.ADDR_W(ADDR_W), .MUX_W(MUX_W), .DATA_W(DATA_W)) bus ();

    adc_scan_sequencer #(
        .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .MUX_W(MUX_W), .DATA_W(DATA_W),
        .INVERT(INVERT), .IGNORED_CHANNEL(IGNORED_CHANNEL), .POWER_CHANNEL(POWER_CHANNEL),
        .AVG_LOG2(AVG_LOG2), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_addr   = 0;   // cycle in which the current channel address became valid

    // Reference model state
    int m_ch, m_sum, m_n, m_power, m_ovf;
    bit m_tflag;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_ch = 0; m_sum = 0; m_n = 0; m_power = 0; m_ovf = 0; m_tflag = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_adc_request",  32'(bus.adc_request),  0);
        check("rst_ch_addr",      32'(bus.ch_addr),      0);
        check("rst_mux_addr",     32'(bus.mux_addr),     0);
        check("rst_bank_en",      32'(bus.bank_en),      1);
        check("rst_fifo_wr",      32'(bus.fifo_wr),      0);
        check("rst_fifo_data",    32'(bus.fifo_data),    0);
        check("rst_power",        32'(bus.power),        0);
        check("rst_power_valid",  32'(bus.power_valid),  0);
        check("rst_scan_done",    32'(bus.scan_done),    0);
        check("rst_overflow_cnt", 32'(bus.overflow_cnt), 0);
        check("rst_timeout_flag", 32'(bus.timeout_flag), 0);
    endtask

    task automatic wait_req(output int r);
        int n = 0;
        while (bus.adc_request !== 1'b1 && n < 4 * SETTLE_CYCLES + 8) begin
            step();
            n++;
        end
        check("req_seen", 32'(bus.adc_request), 1);
        check("req_time", cyc - t_addr, SETTLE_CYCLES);
        check("ch_addr", 32'(bus.ch_addr), m_ch);
        check("mux_addr", 32'(bus.mux_addr), m_ch % (1 << MUX_W));
        check("bank_en", 32'(bus.bank_en), 1 << (m_ch >> MUX_W));
        r = cyc;
    endtask

    // One channel visit. d = reply delay after the request (0 = never reply).
    task automatic txn(input int d, input int v, input bit full, input bit spur);
        int r, s, val, old_ch;
        bit exp_wr, exp_pv, early;
        if (spur) begin
            step();
            step();
            bus.sample_valid = 1'b1;
            bus.sample_data  = DATA_W'($urandom);
            step();
            bus.sample_valid = 1'b0;
        end
        wait_req(r);
        bus.fifo_full = full;
        s = (d > 0) ? r + d + 1 : r + TIMEOUT + 1;
        early = 1'b0;
        while (cyc < s - 1) begin
            step();
            early |= bus.fifo_wr | bus.power_valid | bus.adc_request;
            if (d > 0 && cyc == r + d) begin
                bus.sample_valid = 1'b1;
                bus.sample_data  = DATA_W'(v);
            end
        end
        step();
        bus.sample_valid = 1'b0;
        check("no_early_strobe", 32'(early), 0);

        val    = (d > 0) ? ((INVERT != 0) ? FULL_SCALE - (v & FULL_SCALE) : (v & FULL_SCALE)) : FULL_SCALE;
        exp_wr = 1'b0;
        exp_pv = 1'b0;
        if (m_ch == POWER_CHANNEL) begin
            if (d > 0) begin
                m_sum += val;
                m_n++;
                if (m_n == (1 << AVG_LOG2)) begin
                    m_power = m_sum / (1 << AVG_LOG2);
                    exp_pv  = 1'b1;
                    m_sum   = 0;
                    m_n     = 0;
                end
            end
        end else if (m_ch != IGNORED_CHANNEL) begin
            if (!full) exp_wr = 1'b1;
            else if (m_ovf < 255) m_ovf++;
        end
        if (d == 0) m_tflag = 1'b1;

        check("fifo_wr", 32'(bus.fifo_wr), 32'(exp_wr));
        if (exp_wr) check("fifo_data", 32'(bus.fifo_data), val);
        check("power_valid", 32'(bus.power_valid), 32'(exp_pv));
        check("power", 32'(bus.power), m_power);
        check("overflow_cnt", 32'(bus.overflow_cnt), m_ovf);
        check("timeout_flag", 32'(bus.timeout_flag), 32'(m_tflag));
        check("scan_done_early", 32'(bus.scan_done), 0);

        old_ch = m_ch;
        m_ch   = (m_ch + 1) % CH_NUM;
        step();
        check("scan_done", 32'(bus.scan_done), 32'(old_ch == CH_NUM - 1));
        check("fifo_wr_pulse", 32'(bus.fifo_wr), 0);
        check("ch_next", 32'(bus.ch_addr), m_ch);
        t_addr = cyc;
    endtask

    task automatic goto_ch(input int ch);
        while (m_ch != ch) txn(3, 12'h100, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.fifo_full    = 1'b0;
        model_reset();

        reset = 1'b0;
        repeat (3) step();
        check_reset_outputs();
        reset  = 1'b1;
        t_addr = cyc;

        // Power averaging: INVERT=1, so drive complements to store 0x000,0x004,0x008,0x00C.
        for (int k = 0; k < 4; k++) begin
            txn(3, 12'hFFF - 4 * k, 1'b0, 1'b0);
            for (int c = 1; c < CH_NUM; c++) txn(3, 12'h100, 1'b0, 1'b0);
        end
        check("power_avg_plan", 32'(bus.power), 12'h006);

        // Two plain scans, reply 3 cycles after each request with 0x100.
        for (int k = 0; k < 2 * CH_NUM; k++) txn(3, 12'h100, 1'b0, 1'b0);

        // Sample on the timeout expiry cycle plus a spurious strobe in SETTLE.
        goto_ch(2);
        txn(TIMEOUT, 12'h3A5, 1'b0, 1'b1);
        check("tflag_on_race", 32'(bus.timeout_flag), 0);

        // Never reply on ch2: error marker written at request+TIMEOUT+1.
        goto_ch(2);
        txn(0, 0, 1'b0, 1'b0);
        check("tflag_after_timeout", 32'(bus.timeout_flag), 1);

        // FIFO full long enough to saturate the overflow counter.
        for (int k = 0; k < 600; k++) txn($urandom_range(1, 10), int'($urandom), 1'b1, 1'b0);
        check("overflow_saturated", 32'(bus.overflow_cnt), 255);
        for (int k = 0; k < CH_NUM; k++) txn(2, int'($urandom), 1'b0, 1'b0);

        // Randomized mix.
        for (int k = 0; k < 60; k++) begin
            txn(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12), int'($urandom),
                $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        // Reset asserted while waiting for a sample on ch3.
        goto_ch(3);
        bus.fifo_full = 1'b0;
        wait_req(r);
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_outputs();
        model_reset();
        reset  = 1'b1;
        t_addr = cyc;

        for (int k = 0; k < 5 * CH_NUM; k++) begin
            txn($urandom_range(1, 12), int'($urandom), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Parametrised successor to the analog front-end pairing of channel switcher and sample distributor. Drives the analog multiplexer address and bank enables, issues ADC conversion requests after a settling delay, and optionally inverts each returned sample. Routes samples to the analog FIFO, drops the ignored channel, and averages the power channel. It sits between the SPI ADC receiver and the analog FIFO/power controller, on the 80 MHz clock domain.

## Interface
- CH_NUM, 32: channels per scan, 2..2^ADDR_W
- ADDR_W, 5: channel address width
- MUX_W, 3: per-multiplexer address width; upper ADDR_W-MUX_W bits select bank
- DATA_W, 12: sample width
- INVERT, 1: 1 = store (2^DATA_W-1) - sample, 0 = store raw
- IGNORED_CHANNEL, 1: scanned but never written to FIFO
- POWER_CHANNEL, 0: routed only to power averager, never to FIFO
- AVG_LOG2, 2: power averaged over 2^AVG_LOG2 samples
- SETTLE_CYCLES, 8: cycles from address change to request, >=1
- TIMEOUT, 255: max cycles waiting for a sample, >=1

Ports:
- clk  in  1  system clock (clk80 domain)
- reset  in  1  synchronous, active-low
- sample_data  in  DATA_W  sample from SPI ADC receiver
- sample_valid  in  1  one-cycle strobe, sample_data valid
- fifo_full  in  1  analog FIFO full
- adc_request  out  1  one-cycle conversion request
- mux_addr  out  MUX_W  ch_addr[MUX_W-1:0]
- bank_en  out  2^(ADDR_W-MUX_W)  one-hot decode of ch_addr[ADDR_W-1:MUX_W]
- ch_addr  out  ADDR_W  current channel
- fifo_data  out  DATA_W  sample to FIFO
- fifo_wr  out  1  FIFO write strobe
- power  out  DATA_W  averaged power
- power_valid  out  1  one-cycle strobe on power update
- scan_done  out  1  one-cycle strobe on wrap to channel 0
- overflow_cnt  out  8  saturating count of samples dropped on fifo_full
- timeout_flag  out  1  sticky, set on any timeout

## Operation
- States: SETTLE, REQUEST, WAIT, STORE.
- SETTLE: down-counter loaded with SETTLE_CYCLES-1; at 0 go to REQUEST.
- REQUEST: adc_request=1 for exactly this cycle; load timeout counter with TIMEOUT-1; go to WAIT.
- WAIT: on sample_valid go to STORE with the sample latched. On counter reaching 0 without sample_valid, latch error value {DATA_W{1'b1}} (never inverted), set timeout_flag, and go to STORE. sample_valid on the expiry cycle: the sample wins and timeout_flag is not set.
- STORE (one cycle), for the latched value:
  - Channel == POWER_CHANNEL: add the value to the accumulator (DATA_W+AVG_LOG2 bits). A timeout error value is not accumulated. After 2^AVG_LOG2 accumulated samples: power <= acc >> AVG_LOG2, power_valid pulse, accumulator cleared.
  - Channel == IGNORED_CHANNEL: discarded.
  - Any other channel: if fifo_full=0, fifo_wr=1 with fifo_data = processed value. Otherwise the sample is dropped and overflow_cnt increments, saturating at 255.
  - Then advance ch_addr. ch_addr == CH_NUM-1 wraps to 0 and pulses scan_done. Go to SETTLE.
- sample_valid outside WAIT is ignored.
- Arithmetic: inversion is DATA_W-bit unsigned; the power average truncates.
- Reset values: state SETTLE with counter SETTLE_CYCLES-1, ch_addr=0, bank_en=1, mux_addr=0. All strobes 0, fifo_data=0, power=0, accumulator=0, overflow_cnt=0, timeout_flag=0.
- Reset asserted mid-transaction aborts it: nothing is written and the partial accumulator is lost.
- Channels >= CH_NUM are never addressed.

## Timing
- All outputs are registered.
- Address change (or reset release) at cycle t: adc_request is high at t+SETTLE_CYCLES.
- sample_valid at cycle w in WAIT: fifo_wr, fifo_data and power_valid are high at w+1. ch_addr and scan_done update at w+2. The next adc_request is at w+2+SETTLE_CYCLES.
- Timeout: the request at cycle r with no sample puts the error write at r+TIMEOUT+1.
- Full scan with immediate samples: CH_NUM*(SETTLE_CYCLES+3) cycles.

## Test plan
- CH_NUM=4, SETTLE_CYCLES=8, INVERT=1, POWER_CHANNEL=0, IGNORED_CHANNEL=1. Reply to each request 3 cycles later with 12'h100. Required: FIFO writes only for ch2 and ch3, each 12'hEFF. scan_done pulses once per 4 channels. ch_addr sequence 0,1,2,3,0.
- Power averaging, AVG_LOG2=2: ch0 samples 12'h000, 12'h004, 12'h008, 12'h00C (raw, INVERT=0). Required: one power_valid with power=12'h006, and none earlier.
- Never reply on ch2, TIMEOUT=255. Required: fifo_wr with 12'hFFF at request+256, timeout_flag=1, scan continues to ch3.
- Hold fifo_full=1 for 300 stored samples. Required: no fifo_wr and overflow_cnt=255 (saturated). Deassert fifo_full: the next sample is written.
- Assert reset during WAIT on ch3. Required: all outputs at reset values the next cycle, and the first adc_request exactly SETTLE_CYCLES cycles after reset release.
- sample_valid on the same cycle the timeout expires, and a spurious sample_valid in SETTLE. Required: the real sample is stored, timeout_flag stays 0, and the spurious strobe has no effect.
